// File: rtl/ir_queue.sv
// ir_queue: circular instruction/PC buffer between fetch and decode.
// The head entry is shown already split into MIPS fields. When no entry is
// valid, the outputs show the most recently consumed entry, so decode does
// not glitch between instructions.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side. Ready never depends on valid on the same side.
// Valid, once high, is not withdrawn by the queue unless flush_i or reset_ni
// discards the entry.

package codes;

  typedef logic [31:0] size_t;

  // Each encoding is the raw field value, zero-extended. The spare top bit
  // marks an unknown encoding.
  typedef enum logic [6:0] {
    OP_SPECIAL = 7'h00, OP_REGIMM = 7'h01, OP_J     = 7'h02, OP_JAL   = 7'h03,
    OP_BEQ     = 7'h04, OP_BNE    = 7'h05, OP_BLEZ  = 7'h06, OP_BGTZ  = 7'h07,
    OP_ADDI    = 7'h08, OP_ADDIU  = 7'h09, OP_SLTI  = 7'h0A, OP_SLTIU = 7'h0B,
    OP_ANDI    = 7'h0C, OP_ORI    = 7'h0D, OP_XORI  = 7'h0E, OP_LUI   = 7'h0F,
    OP_LB      = 7'h20, OP_LH     = 7'h21, OP_LWL   = 7'h22, OP_LW    = 7'h23,
    OP_LBU     = 7'h24, OP_LHU    = 7'h25, OP_LWR   = 7'h26, OP_SB    = 7'h28,
    OP_SH      = 7'h29, OP_SWL    = 7'h2A, OP_SW    = 7'h2B, OP_SWR   = 7'h2E,
    OP_INVALID = 7'h40
  } opcode_t;

  typedef enum logic [6:0] {
    FUNC_SLL     = 7'h00, FUNC_SRL   = 7'h02, FUNC_SRA   = 7'h03, FUNC_SLLV  = 7'h04,
    FUNC_SRLV    = 7'h06, FUNC_SRAV  = 7'h07, FUNC_JR    = 7'h08, FUNC_JALR  = 7'h09,
    FUNC_SYSCALL = 7'h0C, FUNC_BREAK = 7'h0D, FUNC_MFHI  = 7'h10, FUNC_MTHI  = 7'h11,
    FUNC_MFLO    = 7'h12, FUNC_MTLO  = 7'h13, FUNC_MULT  = 7'h18, FUNC_MULTU = 7'h19,
    FUNC_DIV     = 7'h1A, FUNC_DIVU  = 7'h1B, FUNC_ADD   = 7'h20, FUNC_ADDU  = 7'h21,
    FUNC_SUB     = 7'h22, FUNC_SUBU  = 7'h23, FUNC_AND   = 7'h24, FUNC_OR    = 7'h25,
    FUNC_XOR     = 7'h26, FUNC_NOR   = 7'h27, FUNC_SLT   = 7'h2A, FUNC_SLTU  = 7'h2B,
    FUNC_INVALID = 7'h40
  } func_t;

  typedef enum logic [5:0] {
    REGIMM_BLTZ    = 6'h00, REGIMM_BGEZ   = 6'h01,
    REGIMM_BLTZAL  = 6'h10, REGIMM_BGEZAL = 6'h11,
    REGIMM_INVALID = 6'h20
  } regimm_t;

endpackage

module ir_queue
  import codes::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  size_t                      instr_i,
  input  logic [PC_WIDTH-1:0]        pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output size_t                      instr_o,
  output logic [PC_WIDTH-1:0]        pc_o,
  output opcode_t                    opcode_o,
  output func_t                      funct_o,
  output regimm_t                    regimm_o,
  output logic [4:0]                 rs_o,
  output logic [4:0]                 rt_o,
  output logic [4:0]                 rd_o,
  output logic [4:0]                 shift_o,
  output logic [15:0]                immediate_o,
  output logic [25:0]                target_o,
  output logic                       invalid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]         mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic [31:0]         last_instr;
  logic [PC_WIDTH-1:0] last_pc;

  logic                empty, push, pop, pass_through;
  logic [31:0]         pres_instr;
  logic [PC_WIDTH-1:0] pres_pc;

  assign empty        = (count == '0);
  assign in_ready_o   = reset_ni && !flush_i && (count != FULL_CNT);
  assign out_valid_o  = reset_ni && !flush_i && (!empty || ((BYPASS != 0) && in_valid_i));
  assign push         = in_valid_i && in_ready_o;
  assign pop          = out_valid_o && out_ready_i;
  // Empty with a same-cycle pop: the word goes straight through, never stored.
  assign pass_through = empty && push && pop;
  assign count_o      = count;

  // Select the presented entry: stored head, bypassed input, or held last pop
  always_comb begin
    pres_instr = last_instr;
    pres_pc    = last_pc;
    if (out_valid_o) begin
      if (empty) begin
        pres_instr = instr_i;
        pres_pc    = pc_i;
      end else begin
        pres_instr = mem_instr[rd_ptr];
        pres_pc    = mem_pc[rd_ptr];
      end
    end
  end

  // Write the incoming entry into storage unless it passed straight through
  always_ff @(posedge clk) begin
    if (push && !pass_through) begin
      mem_instr[wr_ptr] <= instr_i;
      mem_pc[wr_ptr]    <= pc_i;
    end
  end

  // Pointer, occupancy and holding-register update
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else if (flush_i) begin
      // push and pop are already blocked by flush_i; last is kept
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !pass_through) wr_ptr <= wr_ptr + AW'(1);
      if (pop && !pass_through)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)          count  <= count + CW'(1);
      else if (pop && !push)     count  <= count - CW'(1);
      if (pop) begin
        last_instr <= pres_instr;
        last_pc    <= pres_pc;
      end
    end
  end

  function automatic opcode_t map_opcode(input logic [5:0] v);
    case (v)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E:
        map_opcode = opcode_t'({1'b0, v});
      default: map_opcode = OP_INVALID;
    endcase
  endfunction

  function automatic func_t map_funct(input logic [5:0] v);
    case (v)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
      6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
      6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h2A, 6'h2B:
        map_funct = func_t'({1'b0, v});
      default: map_funct = FUNC_INVALID;
    endcase
  endfunction

  function automatic regimm_t map_regimm(input logic [4:0] v);
    case (v)
      5'h00, 5'h01, 5'h10, 5'h11: map_regimm = regimm_t'({1'b0, v});
      default:                    map_regimm = REGIMM_INVALID;
    endcase
  endfunction

  // Field split of the presented word
  assign instr_o     = pres_instr;
  assign pc_o        = pres_pc;
  assign opcode_o    = map_opcode(pres_instr[31:26]);
  assign funct_o     = map_funct(pres_instr[5:0]);
  assign regimm_o    = map_regimm(pres_instr[20:16]);
  assign rs_o        = pres_instr[25:21];
  assign rt_o        = pres_instr[20:16];
  assign rd_o        = pres_instr[15:11];
  assign shift_o     = pres_instr[10:6];
  assign immediate_o = pres_instr[15:0];
  assign target_o    = pres_instr[25:0];
  assign invalid_o   = (opcode_o == OP_INVALID) ||
                       ((opcode_o == OP_SPECIAL) && (funct_o == FUNC_INVALID)) ||
                       ((opcode_o == OP_REGIMM) && (regimm_o == REGIMM_INVALID));

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: one bypass instance checked every cycle against a
// queue model, one non-bypass instance for the fill/drain sequence.
module tb_ir_queue;
  import codes::*;

  localparam int DEPTH = 4;
  localparam int PW    = 32;
  // Legal field values as bit masks (bit n set = value n is defined)
  localparam logic [63:0] OP_LEGAL   = 64'h0000_4F7F_0000_FFFF;
  localparam logic [63:0] FUNC_LEGAL = 64'h0000_0CFF_0F0F_33DD;
  localparam logic [31:0] RI_LEGAL   = 32'h0003_0003;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_ni = 1'b1;
  always #5 clk = ~clk;

  // ---------------- bypass instance (a_) ----------------
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_invalid;
  logic [31:0] a_instr_i, a_instr_o;
  logic [PW-1:0] a_pc_i, a_pc_o;
  opcode_t a_opcode; func_t a_funct; regimm_t a_regimm;
  logic [4:0] a_rs, a_rt, a_rd, a_shift;
  logic [15:0] a_imm; logic [25:0] a_target; logic [2:0] a_count;

  ir_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .BYPASS(1)) u_dut_a (
    .clk(clk), .reset_ni(reset_ni), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .instr_i(a_instr_i), .pc_i(a_pc_i),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .instr_o(a_instr_o), .pc_o(a_pc_o),
    .opcode_o(a_opcode), .funct_o(a_funct), .regimm_o(a_regimm),
    .rs_o(a_rs), .rt_o(a_rt), .rd_o(a_rd), .shift_o(a_shift),
    .immediate_o(a_imm), .target_o(a_target), .invalid_o(a_invalid), .count_o(a_count));

  // ---------------- non-bypass instance (b_) ----------------
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_invalid;
  logic [31:0] b_instr_i, b_instr_o;
  logic [PW-1:0] b_pc_i, b_pc_o;
  opcode_t b_opcode; func_t b_funct; regimm_t b_regimm;
  logic [4:0] b_rs, b_rt, b_rd, b_shift;
  logic [15:0] b_imm; logic [25:0] b_target; logic [2:0] b_count;

  ir_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset_ni(reset_ni), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .instr_i(b_instr_i), .pc_i(b_pc_i),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .instr_o(b_instr_o), .pc_o(b_pc_o),
    .opcode_o(b_opcode), .funct_o(b_funct), .regimm_o(b_regimm),
    .rs_o(b_rs), .rt_o(b_rt), .rd_o(b_rd), .shift_o(b_shift),
    .immediate_o(b_imm), .target_o(b_target), .invalid_o(b_invalid), .count_o(b_count));

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];      // {instr, pc} entries held by the queue
  logic [63:0] last_m = '0;   // entry taken by the latest pop
  logic        exp_valid_m, exp_ready_m;
  logic [63:0] pres_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected decode of a word, from the legal-value masks
  task automatic check_decode(input logic [31:0] w);
    logic [6:0] e_op, e_fn;
    logic [5:0] e_ri;
    logic       e_inv;
    e_op  = OP_LEGAL[w[31:26]]   ? {1'b0, w[31:26]} : 7'h40;
    e_fn  = FUNC_LEGAL[w[5:0]]   ? {1'b0, w[5:0]}   : 7'h40;
    e_ri  = RI_LEGAL[w[20:16]]   ? {1'b0, w[20:16]} : 6'h20;
    e_inv = !OP_LEGAL[w[31:26]] ||
            (w[31:26] == 6'h00 && !FUNC_LEGAL[w[5:0]]) ||
            (w[31:26] == 6'h01 && !RI_LEGAL[w[20:16]]);
    check("opcode", a_opcode, e_op);
    check("funct", a_funct, e_fn);
    check("regimm", a_regimm, e_ri);
    check("rs", a_rs, w[25:21]);
    check("rt", a_rt, w[20:16]);
    check("rd", a_rd, w[15:11]);
    check("shift", a_shift, w[10:6]);
    check("imm", a_imm, w[15:0]);
    check("target", a_target, w[25:0]);
    check("invalid", a_invalid, e_inv);
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs to instance a, then move to the sampling (falling) edge
  task automatic drive_a(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic rdy, input logic fl);
    a_in_valid = v; a_instr_i = w; a_pc_i = pc; a_out_ready = rdy; a_flush = fl;
    @(negedge clk);
  endtask

  task automatic check_model();
    int cnt;
    cnt = exp_q.size();
    exp_ready_m = reset_ni && !a_flush && (cnt < DEPTH);
    exp_valid_m = reset_ni && !a_flush && (cnt > 0 || a_in_valid);
    if (exp_valid_m) pres_m = (cnt > 0) ? exp_q[0] : {a_instr_i, a_pc_i};
    else             pres_m = last_m;
    check("in_ready", a_in_ready, exp_ready_m);
    check("out_valid", a_out_valid, exp_valid_m);
    check("count", a_count, cnt);
    check("instr", a_instr_o, pres_m[63:32]);
    check("pc", a_pc_o, pres_m[31:0]);
    check_decode(pres_m[63:32]);
  endtask

  // Commit this cycle's transfers to the model and cross the rising edge
  task automatic advance();
    logic push, pop;
    if (a_flush) begin
      exp_q.delete();
    end else begin
      push = a_in_valid && exp_ready_m;
      pop  = exp_valid_m && a_out_ready;
      if (pop) begin
        last_m = pres_m;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else push = 1'b0;
      end
      if (push) exp_q.push_back({a_instr_i, a_pc_i});
    end
    @(posedge clk);
    #1;
  endtask

  // Called at the sampling edge: reset mid-cycle, check, release after next edge
  task automatic do_reset();
    #1 reset_ni = 1'b0;
    #1;
    exp_q.delete();
    last_m = '0;
    check("rst_count", a_count, 0);
    check("rst_valid", a_out_valid, 0);
    check("rst_instr", a_instr_o, 0);
    check("rst_opcode", a_opcode, OP_SPECIAL);
    check("rst_funct", a_funct, FUNC_SLL);
    check_model();
    @(posedge clk);
    #1 reset_ni = 1'b1;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] w, input logic rdy);
    b_in_valid = v; b_instr_i = w; b_pc_i = 32'h400 + {w[7:0], 2'b00}; b_out_ready = rdy;
    @(negedge clk);
  endtask

  logic [31:0] pool [8] = '{32'h20010005, 32'h00221820, 32'h0C000010, 32'h04110002,
                            32'h8C430004, 32'hFC000000, 32'h0000003F, 32'h00000000};
  logic [31:0] fill_w [4] = '{32'h20010005, 32'h00221820, 32'h0C000010, 32'h04110002};

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_instr_i = 0; a_pc_i = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_instr_i = 0; b_pc_i = 0;

    // reset values while reset is held
    #2 reset_ni = 1'b0;
    @(negedge clk);
    check("init_ready", a_in_ready, 0);
    check("init_regimm", a_regimm, REGIMM_BLTZ);
    check_model();
    @(posedge clk);
    #1 reset_ni = 1'b1;

    // bypass: empty queue, word falls straight through
    drive_a(1, 32'h8C430004, 32'h100, 1, 0);
    check_model();
    check("byp_valid", a_out_valid, 1);
    check("byp_op", a_opcode, OP_LW);
    check("byp_imm", a_imm, 16'h4);
    check("byp_count", a_count, 0);
    advance();
    drive_a(0, 32'h0, 32'h0, 1, 0);
    check_model();
    check("byp_hold", a_instr_o, 32'h8C430004);
    advance();

    // wrap with simultaneous push/pop at count 2
    for (int k = 0; k < 2; k++) begin
      drive_a(1, pool[k], 32'hBFC00000 + 32'(4 * k), 0, 0);
      check_model();
      advance();
    end
    for (int k = 0; k < 10; k++) begin
      drive_a(1, pool[(k + 2) % 8], 32'hBFC00000 + 32'(4 * (k + 2)), 1, 0);
      check_model();
      check("wrap_count", a_count, 2);
      check("wrap_pc", a_pc_o, 32'hBFC00000 + 32'(4 * k));
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      drive_a(0, 0, 0, 1, 0);
      check_model();
      advance();
    end

    // flush at count 3 with an input offered
    drive_a(1, 32'h20010005, 32'h200, 1, 0); check_model(); advance();
    for (int k = 0; k < 3; k++) begin
      drive_a(1, pool[k + 1], 32'h204 + 32'(4 * k), 0, 0);
      check_model();
      advance();
    end
    drive_a(1, 32'h8C430004, 32'h300, 1, 1);
    check_model();
    check("flush_ready", a_in_ready, 0);
    advance();
    drive_a(0, 0, 0, 0, 0);
    check_model();
    check("flush_count", a_count, 0);
    check("flush_valid", a_out_valid, 0);
    check("flush_last", a_instr_o, 32'h20010005);
    advance();

    // invalid decode
    drive_a(1, 32'hFC000000, 32'h500, 0, 0);
    check_model();
    check("inv_op_flag", a_invalid, 1);
    check("inv_op", a_opcode, OP_INVALID);
    advance();
    drive_a(1, 32'h0000003F, 32'h504, 1, 0); check_model(); advance();
    drive_a(0, 0, 0, 1, 0);
    check_model();
    check("inv_fn", a_funct, FUNC_INVALID);
    check("inv_fn_flag", a_invalid, 1);
    advance();

    // reset mid-stream at count 3
    for (int k = 0; k < 3; k++) begin
      drive_a(1, pool[k], 32'h600 + 32'(4 * k), 0, 0);
      check_model();
      advance();
    end
    drive_a(0, 0, 0, 0, 0);
    check_model();
    do_reset();
    drive_a(0, 0, 0, 0, 0);
    check("post_rst_ready", a_in_ready, 1);
    check_model();
    advance();

    // fill/drain on the non-bypass instance
    for (int i = 0; i < 4; i++) begin
      drive_b(1, fill_w[i], 0);
      check("b_fill_valid", b_out_valid, (i > 0));
      check("b_fill_count", b_count, i);
      @(posedge clk); #1;
    end
    drive_b(0, 0, 0);
    check("b_full_ready", b_in_ready, 0);
    check("b_full_count", b_count, 4);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive_b(0, 0, 1);
      check("b_drain_valid", b_out_valid, 1);
      check("b_drain_instr", b_instr_o, fill_w[i]);
      check("b_drain_ready", b_in_ready, (i > 0));
      case (i)
        0: begin
          check("b_addi", b_opcode, OP_ADDI);
          check("b_addi_rt", b_rt, 1);
          check("b_addi_imm", b_imm, 5);
        end
        1: begin
          check("b_add", b_funct, FUNC_ADD);
          check("b_add_rd", b_rd, 3);
        end
        2: begin
          check("b_jal", b_opcode, OP_JAL);
          check("b_jal_tgt", b_target, 26'h10);
        end
        default: check("b_bgezal", b_regimm, REGIMM_BGEZAL);
      endcase
      @(posedge clk); #1;
    end
    drive_b(0, 0, 0);
    check("b_empty_valid", b_out_valid, 0);
    check("b_empty_hold", b_instr_o, fill_w[3]);
    check("b_empty_inv", b_invalid, 0);
    @(posedge clk); #1;

    // randomized traffic on the bypass instance
    for (int c = 0; c < 1500; c++) begin
      w = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      drive_a($urandom_range(0, 99) < 70, w, $urandom,
              $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 4);
      check_model();
      if ($urandom_range(0, 299) == 0) do_reset();
      else advance();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised successor to the single-entry instruction register. Buffers up to DEPTH fetched instructions with their PCs in a circular FIFO, using valid/ready handshakes on both sides. Presents the head entry already split into MIPS fields using the `codes` package enums. Sits between instruction memory fetch and the control/decode path, letting fetch run ahead of execution; supports a flush for taken branches/jumps.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PC_WIDTH, 32, width of the PC tag carried with each instruction.
- BYPASS, 1, 1 = fall-through: when empty, the input is presented on the output in the same cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous discard of all entries.
- in_valid_i  in  1  fetch offers instr_i/pc_i.
- in_ready_o  out  1  queue accepts this cycle.
- instr_i  in  32  instruction word (size_t).
- pc_i  in  PC_WIDTH  address of instr_i.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer takes head.
- instr_o  out  32  presented instruction word.
- pc_o  out  PC_WIDTH  presented PC.
- opcode_o  out  opcode_t  [31:26] mapped; unknown → OP_INVALID.
- funct_o  out  func_t  [5:0] mapped; unknown → FUNC_INVALID.
- regimm_o  out  regimm_t  [20:16] mapped; unknown → REGIMM_INVALID.
- rs_o / rt_o / rd_o  out  5 each  [25:21] / [20:16] / [15:11].
- shift_o  out  5  [10:6].
- immediate_o  out  16  [15:0].
- target_o  out  26  [25:0].
- invalid_o  out  1  opcode OP_INVALID, or OP_SPECIAL with FUNC_INVALID, or OP_REGIMM with REGIMM_INVALID.
- count_o  out  $clog2(DEPTH+1)  stored entries.

## Operation
- Storage: DEPTH × {instr, pc}; rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1→0); count 0..DEPTH.
- in_ready_o = reset_ni && !flush_i && (count < DEPTH). No same-cycle push-on-full, even if popping.
- push = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
- Stored mode (count > 0): out_valid_o = !flush_i; outputs show mem[rd_ptr].
- Bypass (BYPASS=1, count==0): out_valid_o = in_valid_i && !flush_i; outputs show instr_i/pc_i. If push && pop, nothing is written and the pointers do not move.
- BYPASS=0 or empty without bypass input: out_valid_o = 0.
- Holding register `last` {instr, pc}: loaded with the presented entry on every pop. When out_valid_o=0, all outputs (instr_o, pc_o, decoded fields) show `last`, so decode stays stable between instructions.
- count update: push only +1; pop only −1; both → unchanged (pointers both advance).
- flush_i: next state count=0, rd_ptr=wr_ptr=0; no push or pop occurs in the flush cycle; `last` unchanged.
- Decode is purely combinational from the presented word; invalid_o = 0 for word 0 (SLL nop).

## Timing
- Reset (async assert, while reset_ni=0): count_o=0, pointers 0, `last`=0. Outputs: out_valid_o=0, in_ready_o=0, instr_o=0, pc_o=0, opcode_o=OP_SPECIAL, funct_o=FUNC_SLL, regimm_o=REGIMM_BLTZ, all fields 0, invalid_o=0. Reset release is synchronised by the caller.
- Reset mid-operation: all entries discarded immediately; no partial pop is recorded.
- Latency from push to out_valid_o: 0 cycles via bypass when empty with BYPASS=1; otherwise 1 cycle.
- Throughput: one push and one pop per cycle sustained at any count < DEPTH.
- Full (count==DEPTH): in_ready_o=0 until the cycle after a pop.
- Empty: out_valid_o follows the bypass rule; no pop underflow is possible.
- Simultaneous flush and push/pop: flush wins; the input word is dropped and the head is not consumed.

## Test plan
- Reset: assert reset_ni=0 mid-stream with count=3 → same cycle count_o=0, out_valid_o=0, instr_o=0, opcode_o=OP_SPECIAL, funct_o=FUNC_SLL; after release, in_ready_o=1.
- Fill/drain, DEPTH=4, BYPASS=0, out_ready_i=0: push 0x20010005, 0x00221820, 0x0C000010, 0x04110002 → in_ready_o=0 at count 4. Drain → outputs in order: OP_ADDI rt=1 imm=5; FUNC_ADD rd=3; OP_JAL target=0x10; REGIMM_BGEZAL.
- Bypass: empty, BYPASS=1, push 0x8C430004 with out_ready_i=1 → same cycle out_valid_o=1, opcode_o=OP_LW, immediate_o=4; count_o stays 0. Next cycle with no input, outputs hold 0x8C430004.
- Wrap plus simultaneous push/pop: 10 cycles of push+pop at count=2 → count_o constant 2, pointers wrap, PCs pop in order 0xBFC00000+4k.
- Flush: count=3, flush_i together with in_valid_i → next cycle count_o=0, out_valid_o=0, input dropped; `last` still shows the previous pop.
- Invalid decode: push 0xFC000000, then 0x0000003F → invalid_o=1, opcode_o=OP_INVALID, then funct_o=FUNC_INVALID.
